// File: rtl/tick_sched_ctrl.sv
// Run-control sequencer for the tick/prescaler path: programmable divisor, continuous or burst runs.
// Optional freeze input is compiled in with TICK_SCHED_PAUSE_EN.
module tick_sched_ctrl #(
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 24999999,
  parameter int BURST_W     = 8
) (
  input  logic               clk,
  input  logic               reset_button,
  input  logic               cfg_valid,
  input  logic [CNT_W-1:0]   cfg_div,
  output logic               cfg_ready,
  input  logic               cmd_start,
  input  logic               cmd_burst,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               cmd_stop,
`ifdef TICK_SCHED_PAUSE_EN
  input  logic               pause,
`endif
  output logic               tick,
  output logic               clk_out,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] tick_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   ctr_q, ctr_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] remain_q, remain_d;
  logic [BURST_W-1:0] tcnt_q, tcnt_d;
  logic               tick_q, tick_d;
  logic               clk_out_q, clk_out_d;
  logic               done_q, done_d;

  logic frozen;
  logic term;
  logic cfg_accept;

`ifdef TICK_SCHED_PAUSE_EN
  assign frozen = pause;
`else
  assign frozen = 1'b0;
`endif

  assign term       = (ctr_q == div_q);
  assign cfg_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign cfg_accept = cfg_valid && cfg_ready;

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    div_d     = div_q;
    remain_d  = remain_q;
    tcnt_d    = tcnt_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A divisor accepted together with a command is already in div_q when counting begins.
        if (cfg_accept) begin
          div_d = cfg_div;
        end
        if (cmd_stop) begin
          state_d = S_IDLE;
        end else if (cmd_start) begin
          state_d = S_RUN;
          ctr_d   = '0;
          tcnt_d  = '0;
        end else if (cmd_burst) begin
          tcnt_d = '0;
          if (burst_len != '0) begin
            state_d  = S_BURST;
            remain_d = burst_len;
            ctr_d    = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_RUN, S_BURST: begin
        if (cmd_stop) begin
          // Stop wins over a coincident terminal count: no tick, no count.
          state_d   = S_IDLE;
          ctr_d     = '0;
          clk_out_d = 1'b0;
        end else if (!frozen) begin
          if (term) begin
            ctr_d     = '0;
            tick_d    = 1'b1;
            clk_out_d = ~clk_out_q;
            tcnt_d    = tcnt_q + BURST_W'(1);
            if (state_q == S_BURST) begin
              remain_d = remain_q - BURST_W'(1);
              if (remain_q == BURST_W'(1)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end
          end else begin
            ctr_d = ctr_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        ctr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_button) begin
      state_q   <= S_IDLE;
      ctr_q     <= '0;
      div_q     <= CNT_W'(DEFAULT_DIV);
      remain_q  <= '0;
      tcnt_q    <= '0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      div_q     <= div_d;
      remain_q  <= remain_d;
      tcnt_q    <= tcnt_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      done_q    <= done_d;
    end
  end

  assign tick       = tick_q;
  assign clk_out    = clk_out_q;
  assign done       = done_q;
  assign tick_count = tcnt_q;

`ifndef SYNTHESIS
  // done is only ever raised on the edge that lands in IDLE.
  a_done_idle: assert property (@(posedge clk) disable iff (reset_button) done |-> !busy);
`endif

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Self-checking bench for tick_sched_ctrl: directed scenarios with literal expectations plus a
// randomized phase compared every cycle against an active-cycle-count reference model.
module tb_tick_sched_ctrl;
  localparam int CNT_W       = 26;
  localparam int DEFAULT_DIV = 24999999;
  localparam int BURST_W     = 8;

  logic               clk;
  logic               rst;
  logic               cfg_valid;
  logic [CNT_W-1:0]   cfg_div;
  logic               cfg_ready;
  logic               cmd_start;
  logic               cmd_burst;
  logic [BURST_W-1:0] burst_len;
  logic               cmd_stop;
  logic               pause;
  logic               tick;
  logic               clk_out;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] tick_count;

  int n_tests = 0;
  int n_fail  = 0;

  tick_sched_ctrl #(
    .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV), .BURST_W(BURST_W)
  ) dut (
    .clk(clk),
    .reset_button(rst),
    .cfg_valid(cfg_valid),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
    .cmd_start(cmd_start),
    .cmd_burst(cmd_burst),
    .burst_len(burst_len),
    .cmd_stop(cmd_stop),
`ifdef TICK_SCHED_PAUSE_EN
    .pause(pause),
`endif
    .tick(tick),
    .clk_out(clk_out),
    .busy(busy),
    .done(done),
    .tick_count(tick_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: ticks fall on every (div+1)-th unfrozen counting cycle since the run began.
  int     m_mode;          // 0 idle, 1 continuous, 2 burst
  longint m_div;
  longint m_active;
  int     m_left;
  bit     m_tick, m_clk, m_done, m_valid;
  int     m_cnt;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    bit pz;
`ifdef TICK_SCHED_PAUSE_EN
    pz = pause;
`else
    pz = 1'b0;
`endif
    if (rst) begin
      m_mode = 0; m_div = DEFAULT_DIV; m_active = 0; m_left = 0;
      m_tick = 0; m_clk = 0; m_done = 0; m_cnt = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_tick = 0;
      m_done = 0;
      if (m_mode == 0) begin
        if (cfg_valid) m_div = cfg_div;
        if (cmd_stop) begin
        end else if (cmd_start) begin
          m_mode = 1; m_active = 0; m_cnt = 0;
        end else if (cmd_burst) begin
          m_cnt = 0;
          if (burst_len > 0) begin
            m_mode = 2; m_left = burst_len; m_active = 0;
          end else begin
            m_done = 1;
          end
        end
      end else if (cmd_stop) begin
        m_mode = 0; m_clk = 0;
      end else if (!pz) begin
        m_active++;
        if (m_active % (m_div + 1) == 0) begin
          m_tick = 1;
          m_clk  = !m_clk;
          m_cnt  = (m_cnt + 1) % (1 << BURST_W);
          if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) begin
              m_mode = 0; m_done = 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_tick", tick, m_tick);
      chk("m_clk_out", clk_out, m_clk);
      chk("m_done", done, m_done);
      chk("m_busy", busy, m_mode != 0);
      chk("m_cfg_ready", cfg_ready, m_mode == 0);
      chk("m_tick_count", tick_count, m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; cmd_start = 0; cmd_burst = 0; cmd_stop = 0; burst_len = '0;
  endtask

  initial begin
    int seen;
    rst = 1; pause = 0; cfg_div = '0;
    idle_inputs();
    cyc();
    cyc();
    chk("rst_tick", tick, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_tick_count", tick_count, 0);
    rst = 0;

    // Default divisor: no tick anywhere near the start.
    cmd_start = 1; cyc(); cmd_start = 0;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      cyc();
      if (tick) seen++;
    end
    chk("default_no_tick", seen, 0);
    chk("default_busy", busy, 1);
    cmd_stop = 1; cyc(); cmd_stop = 0;
    chk("stop_busy", busy, 0);

    // Divisor 3, continuous run.
    cfg_valid = 1; cfg_div = 3; cyc(); cfg_valid = 0;
    cmd_start = 1; cyc(); cmd_start = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("run3_tick", tick, (k % 4) == 0);
      chk("run3_clk_out", clk_out, (k / 4) % 2);
    end
    chk("run3_count", tick_count, 3);
    cmd_stop = 1; cyc(); cmd_stop = 0;

    // Burst of 5 with divisor 1.
    cfg_valid = 1; cfg_div = 1; cyc(); cfg_valid = 0;
    cmd_burst = 1; burst_len = 5; cyc(); cmd_burst = 0; burst_len = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("burst_tick", tick, (k % 2) == 0);
      chk("burst_done", done, k == 10);
    end
    chk("burst_busy_end", busy, 0);
    chk("burst_count", tick_count, 5);
    chk("burst_clk_out", clk_out, 1);
    cyc();
    chk("burst_done_clear", done, 0);
    chk("burst_clk_hold", clk_out, 1);

    // Burst of zero.
    cmd_burst = 1; burst_len = 0; cyc(); cmd_burst = 0;
    chk("zero_done", done, 1);
    chk("zero_tick", tick, 0);
    chk("zero_busy", busy, 0);
    cyc();
    chk("zero_done_clear", done, 0);

    // Stop on the terminal-count cycle, with a config request held through the run.
    cfg_valid = 1; cfg_div = 3; cyc(); cfg_valid = 0;
    cmd_start = 1; cyc(); cmd_start = 0;
    cfg_valid = 1; cfg_div = 7;
    for (int k = 1; k <= 3; k++) cyc();
    cmd_stop = 1; cyc(); cmd_stop = 0;
    chk("stoptc_tick", tick, 0);
    chk("stoptc_clk_out", clk_out, 0);
    chk("stoptc_busy", busy, 0);
    chk("stoptc_ready", cfg_ready, 1);
    cyc(); cfg_valid = 0;
    cmd_start = 1; cyc(); cmd_start = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("div7_tick", tick, k == 8);
    end
    cmd_stop = 1; cyc(); cmd_stop = 0;

    // Start and stop together in IDLE.
    cmd_start = 1; cmd_stop = 1; cyc(); idle_inputs();
    chk("startstop_busy", busy, 0);
    cyc();
    chk("startstop_busy2", busy, 0);

`ifdef TICK_SCHED_PAUSE_EN
    cfg_valid = 1; cfg_div = 3; cyc(); cfg_valid = 0;
    cmd_start = 1; cyc(); cmd_start = 0;
    for (int k = 1; k <= 20; k++) begin
      pause = (k >= 7 && k <= 16);
      cyc();
      chk("pause_tick", tick, (k == 4) || (k == 18));
      if (k == 17) chk("pause_count", tick_count, 1);
      chk("pause_busy", busy, 1);
    end
    pause = 0;
    cmd_stop = 1; cyc(); cmd_stop = 0;
`endif

    // Randomized phase against the model.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_div   = CNT_W'($urandom_range(0, 5));
      cmd_start = ($urandom_range(0, 19) == 0);
      cmd_burst = ($urandom_range(0, 14) == 0);
      burst_len = BURST_W'($urandom_range(0, 6));
      cmd_stop  = ($urandom_range(0, 39) == 0);
`ifdef TICK_SCHED_PAUSE_EN
      pause     = ($urandom_range(0, 5) == 0);
`endif
      cyc();
    end
    rst = 0; idle_inputs(); pause = 0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
